// File: rtl/xlr8_anapin_arb.sv
// xlr8_anapin_arb
//   Sequences the board pin resources shared by the ADC and the I2C master:
//   the A0-A5 digital-isolation switches, the A4/A5 I2C pullup enable and the
//   ADC reference select. The block arbitrates ADC vs I2C ownership of A4/A5.
//   It inserts a settle delay after isolating or dropping pullups, and a
//   recovery delay after pullups come back, before granting either side.
//
// Ports
//   clk, rst          core clock, async active-high reset
//   adc_req/chan/done ADC handshake; chan 0-5 = pins A0-A5, 6-7 = internal
//   adc_gnt           ADC may convert
//   i2c_req/done      I2C handshake
//   i2c_gnt           I2C may drive SDA/SCL
//   ana_up_cfg/ana_up requested / registered ADC reference select
//   dig_io_iso        per-pin isolate (1 = pad drives DIG_IO_OE low)
//   i2c_enable        A4/A5 pullup enable
//   busy              either FSM not idle
// All outputs are flops; nothing combinational reaches a pin.
`timescale 1ns/1ps
module xlr8_anapin_arb #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int RECOVER_CYCLES = 32,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       adc_req,
  input  logic [2:0] adc_chan,
  input  logic       adc_done,
  output logic       adc_gnt,
  input  logic       i2c_req,
  input  logic       i2c_done,
  output logic       i2c_gnt,
  input  logic       ana_up_cfg,
  output logic       ana_up,
  output logic [5:0] dig_io_iso,
  output logic       i2c_enable,
  output logic       busy
);

  typedef enum logic [1:0] {A_IDLE, A_WAIT, A_SETTLE, A_CONV} a_state_t;
  typedef enum logic [1:0] {I_IDLE, I_RECOVER, I_OWN}         i_state_t;

  localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] RECOVER_LD = CNT_W'(RECOVER_CYCLES);
  localparam logic             WIN_I2C    = 1'b0;
  localparam logic             WIN_ADC    = 1'b1;

  a_state_t         a_st, a_st_n;
  i_state_t         i_st, i_st_n;
  logic [CNT_W-1:0] a_cnt, a_cnt_n, i_cnt, i_cnt_n;
  logic [2:0]       chan_q, chan_q_n;
  logic             last_win, last_win_n;
  logic             pu_dirty, pu_dirty_n;
  logic             adc_gnt_n, i2c_gnt_n, ana_up_n, en_n, busy_n;
  logic [5:0]       iso_n;

  logic adc_claim, i2c_claim, contest, adc_win, i2c_win, adc_holds;

  // ADC wants A4/A5 and the I2C side is idle: either a fresh request on a
  // shared pin, or a parked request in A_WAIT (which only ever holds 4/5).
  assign adc_claim = (i_st == I_IDLE) &&
                     (((a_st == A_IDLE) && adc_req && (adc_chan[2:1] == 2'b10)) ||
                      (a_st == A_WAIT));

  // ADC owns A4/A5 from settle through conversion. The releasing cycle
  // (adc_done in A_CONV) already counts as free, so the I2C recovery window
  // starts on the same edge that re-enables the pullups.
  assign adc_holds = (chan_q[2:1] == 2'b10) &&
                     ((a_st == A_SETTLE) || ((a_st == A_CONV) && !adc_done));

  assign i2c_claim = (i_st == I_IDLE) && i2c_req && !adc_holds;
  assign contest   = adc_claim && i2c_claim;
  // Contested claims alternate, starting from the opposite of last_win.
  assign adc_win   = adc_claim && (!contest || (last_win == WIN_I2C));
  assign i2c_win   = i2c_claim && (!contest || (last_win == WIN_ADC));

  always_comb begin
    a_st_n     = a_st;
    i_st_n     = i_st;
    a_cnt_n    = a_cnt;
    i_cnt_n    = i_cnt;
    chan_q_n   = chan_q;
    last_win_n = last_win;
    pu_dirty_n = pu_dirty;
    adc_gnt_n  = adc_gnt;
    i2c_gnt_n  = i2c_gnt;
    iso_n      = dig_io_iso;
    en_n       = i2c_enable;
    ana_up_n   = (a_st == A_IDLE) ? ana_up_cfg : ana_up;

    if (contest) last_win_n = adc_win ? WIN_ADC : WIN_I2C;

    // ADC side
    case (a_st)
      A_IDLE: begin
        if (adc_req) begin
          chan_q_n = adc_chan;
          if (adc_chan[2:1] == 2'b11) begin
            a_st_n    = A_CONV;
            adc_gnt_n = 1'b1;
          end else if (adc_chan[2:1] != 2'b10) begin
            a_st_n  = A_SETTLE;
            a_cnt_n = SETTLE_LD;
            iso_n   = 6'b000001 << adc_chan;
          end else if (adc_win) begin
            a_st_n     = A_SETTLE;
            a_cnt_n    = SETTLE_LD;
            iso_n      = 6'b000001 << adc_chan;
            en_n       = 1'b0;
            pu_dirty_n = 1'b1;
          end else begin
            a_st_n = A_WAIT;
          end
        end
      end
      A_WAIT: begin
        if (adc_win) begin
          a_st_n     = A_SETTLE;
          a_cnt_n    = SETTLE_LD;
          iso_n      = 6'b000001 << chan_q;
          en_n       = 1'b0;
          pu_dirty_n = 1'b1;
        end
      end
      A_SETTLE: begin
        if (a_cnt == '0) begin
          a_st_n    = A_CONV;
          adc_gnt_n = 1'b1;
        end else begin
          a_cnt_n = a_cnt - 1'b1;
        end
      end
      A_CONV: begin
        if (adc_done) begin
          a_st_n    = A_IDLE;
          adc_gnt_n = 1'b0;
          iso_n     = '0;
          en_n      = 1'b1;
        end
      end
      default: a_st_n = A_IDLE;
    endcase

    // I2C side
    case (i_st)
      I_IDLE: begin
        if (i2c_win) begin
          if (pu_dirty) begin
            i_st_n  = I_RECOVER;
            i_cnt_n = RECOVER_LD;
          end else begin
            i_st_n    = I_OWN;
            i2c_gnt_n = 1'b1;
          end
        end
      end
      I_RECOVER: begin
        if (i_cnt == '0) begin
          i_st_n     = I_OWN;
          i2c_gnt_n  = 1'b1;
          pu_dirty_n = 1'b0;
        end else begin
          i_cnt_n = i_cnt - 1'b1;
        end
      end
      I_OWN: begin
        if (i2c_done) begin
          i_st_n    = I_IDLE;
          i2c_gnt_n = 1'b0;
        end
      end
      default: i_st_n = I_IDLE;
    endcase

    busy_n = (a_st_n != A_IDLE) || (i_st_n != I_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_st       <= A_IDLE;
      i_st       <= I_IDLE;
      a_cnt      <= '0;
      i_cnt      <= '0;
      chan_q     <= '0;
      last_win   <= WIN_I2C;
      pu_dirty   <= 1'b0;
      adc_gnt    <= 1'b0;
      i2c_gnt    <= 1'b0;
      dig_io_iso <= '0;
      i2c_enable <= 1'b1;
      ana_up     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      a_st       <= a_st_n;
      i_st       <= i_st_n;
      a_cnt      <= a_cnt_n;
      i_cnt      <= i_cnt_n;
      chan_q     <= chan_q_n;
      last_win   <= last_win_n;
      pu_dirty   <= pu_dirty_n;
      adc_gnt    <= adc_gnt_n;
      i2c_gnt    <= i2c_gnt_n;
      dig_io_iso <= iso_n;
      i2c_enable <= en_n;
      ana_up     <= ana_up_n;
      busy       <= busy_n;
    end
  end

endmodule

// File: tb/tb_xlr8_anapin_arb.sv
// Scoreboard bench for xlr8_anapin_arb. Drivers push expected grant events
// (cycle, isolation pattern, pullup state) when they issue requests; a
// negedge monitor pops and checks whenever a grant rises.
`timescale 1ns/1ps
module tb_xlr8_anapin_arb;
  localparam int SETTLE  = 16;
  localparam int RECOVER = 32;

  logic       clk = 1'b0, rst = 1'b1;
  logic       adc_req = 1'b0, adc_done = 1'b0, i2c_req = 1'b0, i2c_done = 1'b0;
  logic [2:0] adc_chan = 3'd0;
  logic       ana_up_cfg = 1'b1;
  logic       adc_gnt, i2c_gnt, ana_up, i2c_enable, busy;
  logic [5:0] dig_io_iso;

  xlr8_anapin_arb #(.SETTLE_CYCLES(SETTLE), .RECOVER_CYCLES(RECOVER), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .adc_req(adc_req), .adc_chan(adc_chan), .adc_done(adc_done),
    .adc_gnt(adc_gnt), .i2c_req(i2c_req), .i2c_done(i2c_done), .i2c_gnt(i2c_gnt),
    .ana_up_cfg(ana_up_cfg), .ana_up(ana_up), .dig_io_iso(dig_io_iso),
    .i2c_enable(i2c_enable), .busy(busy));

  always #5 clk = ~clk;

  typedef struct { int due; logic [5:0] iso; logic en; } exp_t;
  exp_t adc_q[$], i2c_q[$];
  exp_t ea, ei;
  int   n_tests = 0, n_fail = 0;
  int   cyc = 0;
  logic [2:0] cur_chan = 3'd0;
  logic ana_q = 1'b0;
  logic m_dirty = 1'b0;     // pullups were dropped since the last I2C recovery
  logic m_last_adc = 1'b0;  // last contest went to the ADC
  logic pa = 1'b0, pi = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk_adc(input logic [2:0] ch, input int due);
    exp_t e;
    e.due = due;
    e.iso = (ch < 3'd6) ? (6'b000001 << ch) : 6'b0;
    e.en  = !((ch == 3'd4) || (ch == 3'd5));
    return e;
  endfunction

  function automatic exp_t mk_i2c(input int due);
    exp_t e;
    e.due = due; e.iso = 6'b0; e.en = 1'b1;
    return e;
  endfunction

  // monitor
  always @(negedge clk) begin
    if (adc_gnt && !pa) begin
      if (adc_q.size() == 0) chk("adc_unexpected_gnt", 1, 0);
      else begin
        ea = adc_q.pop_front();
        if (ea.due >= 0) chk("adc_gnt_cycle", cyc, ea.due);
        chk("adc_gnt_iso", {26'd0, dig_io_iso}, {26'd0, ea.iso});
        chk("adc_gnt_pullup", {31'd0, i2c_enable}, {31'd0, ea.en});
      end
    end
    if (i2c_gnt && !pi) begin
      if (i2c_q.size() == 0) chk("i2c_unexpected_gnt", 1, 0);
      else begin
        ei = i2c_q.pop_front();
        if (ei.due >= 0) chk("i2c_gnt_cycle", cyc, ei.due);
        chk("i2c_gnt_pullup", {31'd0, i2c_enable}, 1);
      end
    end
    if (adc_gnt && (cur_chan[2:1] == 2'b10)) chk("pullup_off_in_adc_conv", {31'd0, i2c_enable}, 0);
    pa = adc_gnt;
    pi = i2c_gnt;
  end

  task automatic adc_issue(input logic [2:0] ch, input int lat);
    @(negedge clk);
    adc_chan = ch; adc_req = 1'b1; cur_chan = ch;
    ana_up_cfg = 1'($urandom_range(0, 1));
    ana_q = ana_up_cfg;
    if (lat >= 0) adc_q.push_back(mk_adc(ch, cyc + lat));
  endtask

  task automatic adc_wait_gnt();
    int n = 0;
    while (!adc_gnt && n < 300) begin @(negedge clk); n++; end
    if (!adc_gnt) chk("adc_gnt_timeout", 0, 1);
    adc_req = 1'b0;
  endtask

  // hold >= 1; toggles the reference request mid-conversion, then ends it
  task automatic adc_finish(input int hold, input int i2c_lat);
    ana_up_cfg = ~ana_up_cfg;
    repeat (hold) begin @(negedge clk); chk("ana_up_frozen", {31'd0, ana_up}, {31'd0, ana_q}); end
    adc_done = 1'b1;
    if (i2c_lat >= 0) i2c_q.push_back(mk_i2c(cyc + i2c_lat));
    @(negedge clk);
    adc_done = 1'b0;
    chk("adc_done_gnt", {31'd0, adc_gnt}, 0);
    chk("adc_done_iso", {26'd0, dig_io_iso}, 0);
    chk("adc_done_pullup", {31'd0, i2c_enable}, 1);
  endtask

  task automatic i2c_issue(input int lat);
    @(negedge clk);
    i2c_req = 1'b1;
    if (lat >= 0) i2c_q.push_back(mk_i2c(cyc + lat));
  endtask

  task automatic i2c_wait_gnt();
    int n = 0;
    while (!i2c_gnt && n < 300) begin @(negedge clk); n++; end
    if (!i2c_gnt) chk("i2c_gnt_timeout", 0, 1);
    i2c_req = 1'b0;
  endtask

  task automatic i2c_finish(input int hold, input int adc_lat);
    repeat (hold) @(negedge clk);
    i2c_done = 1'b1;
    if (adc_lat >= 0) adc_q.push_back(mk_adc(cur_chan, cyc + adc_lat));
    @(negedge clk);
    i2c_done = 1'b0;
    chk("i2c_done_gnt", {31'd0, i2c_gnt}, 0);
  endtask

  function automatic int i2c_lat_now();
    return m_dirty ? RECOVER + 2 : 1;
  endfunction

  // ADC on A4/A5 and I2C claim on the same edge
  task automatic contest(input logic [2:0] ch);
    logic adc_wins;
    int n;
    adc_wins = !m_last_adc;
    m_last_adc = adc_wins;
    @(negedge clk);
    adc_chan = ch; adc_req = 1'b1; cur_chan = ch; i2c_req = 1'b1;
    ana_q = ana_up_cfg;
    if (adc_wins) adc_q.push_back(mk_adc(ch, cyc + SETTLE + 2));
    else begin i2c_q.push_back(mk_i2c(cyc + i2c_lat_now())); m_dirty = 1'b0; end
    n = 0;
    while (!adc_gnt && !i2c_gnt && n < 300) begin @(negedge clk); n++; end
    chk("contest_winner_adc", {31'd0, adc_gnt}, {31'd0, adc_wins});
    chk("contest_winner_i2c", {31'd0, i2c_gnt}, {31'd0, !adc_wins});
    if (adc_wins) begin
      adc_req = 1'b0;
      adc_finish(2, RECOVER + 2);
      m_dirty = 1'b0;
      i2c_wait_gnt();
      i2c_finish(2, -1);
    end else begin
      i2c_req = 1'b0;
      i2c_finish(2, SETTLE + 3);
      m_dirty = 1'b1;
      adc_wait_gnt();
      adc_finish(2, -1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_adc_gnt", {31'd0, adc_gnt}, 0);
    chk("rst_i2c_gnt", {31'd0, i2c_gnt}, 0);
    chk("rst_iso", {26'd0, dig_io_iso}, 0);
    chk("rst_pullup", {31'd0, i2c_enable}, 1);
    chk("rst_ana_up", {31'd0, ana_up}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    rst = 1'b0;
    @(negedge clk);

    // pin channel 2
    adc_issue(3'd2, SETTLE + 2);
    @(negedge clk);
    chk("ch2_iso_next_edge", {26'd0, dig_io_iso}, 6'b000100);
    chk("ch2_busy", {31'd0, busy}, 1);
    adc_wait_gnt();
    adc_finish(3, -1);

    // channel 4: pullups off, then I2C must recover after release
    adc_issue(3'd4, SETTLE + 2);
    @(negedge clk);
    chk("ch4_pullup_off", {31'd0, i2c_enable}, 0);
    chk("ch4_iso", {26'd0, dig_io_iso}, 6'b010000);
    adc_wait_gnt();
    m_dirty = 1'b1;
    i2c_issue(-1);
    repeat (4) @(negedge clk);
    chk("i2c_blocked_by_adc", {31'd0, i2c_gnt}, 0);
    adc_finish(1, RECOVER + 2);
    m_dirty = 1'b0;
    i2c_wait_gnt();
    i2c_finish(2, -1);

    // three contests: ADC, I2C, ADC
    contest(3'd5);
    contest(3'd5);
    contest(3'd5);

    // ADC on a non-shared pin while I2C owns the bus
    i2c_issue(i2c_lat_now()); m_dirty = 1'b0;
    i2c_wait_gnt();
    adc_issue(3'd1, SETTLE + 2);
    adc_wait_gnt();
    chk("concurrent_i2c_held", {31'd0, i2c_gnt}, 1);
    adc_finish(2, -1);
    // ADC on A4 parks until I2C lets go
    adc_issue(3'd4, -1);
    repeat (5) @(negedge clk);
    chk("wait_no_gnt", {31'd0, adc_gnt}, 0);
    chk("wait_no_iso", {26'd0, dig_io_iso}, 0);
    chk("wait_pullup_on", {31'd0, i2c_enable}, 1);
    i2c_finish(1, SETTLE + 3);
    adc_wait_gnt();
    m_dirty = 1'b1;
    adc_finish(2, -1);

    // internal channel: one-edge grant, no isolation
    adc_issue(3'd7, 1);
    adc_wait_gnt();
    adc_finish(3, -1);

    // async reset in the middle of a chan-4 settle
    adc_issue(3'd4, -1);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    adc_req = 1'b0;
    #1;
    chk("arst_pullup", {31'd0, i2c_enable}, 1);
    chk("arst_iso", {26'd0, dig_io_iso}, 0);
    chk("arst_adc_gnt", {31'd0, adc_gnt}, 0);
    chk("arst_busy", {31'd0, busy}, 0);
    m_dirty = 1'b0; m_last_adc = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // randomized traffic against the model
    for (int it = 0; it < 30; it++) begin
      int kind, hold;
      logic [2:0] ch;
      kind = $urandom_range(0, 3);
      hold = $urandom_range(1, 4);
      ch   = 3'($urandom_range(0, 7));
      case (kind)
        0: begin
          adc_issue(ch, (ch >= 3'd6) ? 1 : SETTLE + 2);
          adc_wait_gnt();
          if (ch[2:1] == 2'b10) m_dirty = 1'b1;
          adc_finish(hold, -1);
        end
        1: begin
          i2c_issue(i2c_lat_now()); m_dirty = 1'b0;
          i2c_wait_gnt();
          i2c_finish(hold, -1);
        end
        2: begin
          if (ch[2:1] == 2'b10) ch = ch - 3'd4;
          i2c_issue(i2c_lat_now()); m_dirty = 1'b0;
          i2c_wait_gnt();
          adc_issue(ch, (ch >= 3'd6) ? 1 : SETTLE + 2);
          adc_wait_gnt();
          chk("rand_concurrent_i2c", {31'd0, i2c_gnt}, 1);
          adc_finish(hold, -1);
          i2c_finish(1, -1);
        end
        default: contest(3'd4 + 3'(ch[0]));
      endcase
    end

    repeat (5) @(negedge clk);
    chk("adc_sb_drained", adc_q.size(), 0);
    chk("i2c_sb_drained", i2c_q.size(), 0);
    chk("idle_busy", {31'd0, busy}, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/xlr8_anapin_arb.md
Name: xlr8_anapin_arb

Overview:
- Sequences the board-level pin resources shared by the ADC and the I2C master.
- Resources controlled: the A0–A5 digital-isolation switches (DIG_IO_OE, driven low to isolate), the A4/A5 I2C pullup enable (I2C_ENABLE) and the ADC reference select (ANA_UP).
- Arbitrates the ADC and I2C requesters, since an ADC conversion on A4/A5 needs the pullups off.
- Inserts settle and recovery delays before granting either requester.
- Sits in xlr8_top between the ADC/I2C XBs and the top-level pins.

Parameters:
- SETTLE_CYCLES, 16, clocks from isolation/pullup-off to adc_gnt (>=1).
- RECOVER_CYCLES, 32, clocks from pullup re-enable to i2c_gnt (>=1).
- CNT_W, 8, settle/recover counter width; must hold max(SETTLE_CYCLES, RECOVER_CYCLES).

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- adc_req  in  1  ADC requests pin access; held high until adc_gnt.
- adc_chan  in  3  channel; 0–5 = pins A0–A5, 6–7 = internal (no pin).
- adc_done  in  1  one-cycle pulse ending the conversion.
- adc_gnt  out  1  ADC may convert.
- i2c_req  in  1  I2C requests bus; held high until i2c_gnt.
- i2c_done  in  1  one-cycle pulse ending the transaction.
- i2c_gnt  out  1  I2C may drive SDA/SCL.
- ana_up_cfg  in  1  requested ADC reference select.
- ana_up  out  1  registered reference select to pin.
- dig_io_iso  out  6  1 = pad drives DIG_IO_OE[i] low; 0 = high-Z.
- i2c_enable  out  1  pullup enable to I2C_ENABLE.
- busy  out  1  either FSM not idle.

Behaviour:
- Reset: adc_gnt=0, i2c_gnt=0, dig_io_iso=0, i2c_enable=1, ana_up=0, busy=0, counters=0, last_win=I2C, pu_dirty=0.
- ADC FSM states: A_IDLE, A_WAIT, A_SETTLE, A_CONV.
  - A_IDLE, adc_req=1: latch adc_chan into chan_q.
    - chan_q >= 6 -> A_CONV; adc_gnt=1 on the next edge (latency 1).
    - chan_q 0–3 -> A_SETTLE; iso[chan_q]=1; counter loaded.
    - chan_q 4/5 with the I2C FSM in I_IDLE and arbitration won -> A_SETTLE; iso[chan_q]=1, i2c_enable=0, pu_dirty=1.
    - chan_q 4/5 otherwise -> A_WAIT.
  - A_WAIT: when the I2C FSM returns to I_IDLE and arbitration is won -> A_SETTLE as above.
  - A_SETTLE: count SETTLE_CYCLES clocks -> A_CONV. adc_gnt rises exactly SETTLE_CYCLES+1 edges after the edge that samples adc_req (uncontended case).
  - A_CONV: adc_gnt held until adc_done. On adc_done: adc_gnt=0, iso cleared, i2c_enable=1 (if it was cleared), -> A_IDLE, all on the same edge.
- I2C FSM states: I_IDLE, I_RECOVER, I_OWN.
  - I_IDLE, i2c_req=1 with the ADC not holding A4/A5 (not in A_SETTLE/A_CONV with chan_q 4/5) and arbitration won:
    - pu_dirty=1 -> I_RECOVER.
    - pu_dirty=0 -> I_OWN; i2c_gnt on the next edge.
  - I_RECOVER: count RECOVER_CYCLES clocks -> I_OWN; clear pu_dirty.
  - I_OWN: i2c_gnt held until i2c_done -> I_IDLE.
- Concurrency: the ADC on channels 0–3 and 6–7 never conflicts; it may be granted while i2c_gnt=1.
- Arbitration:
  - Applies only when A_IDLE/A_WAIT (chan 4/5) and I_IDLE both claim in the same cycle.
  - Winner is the opposite of last_win; last_win updates on every contested grant.
  - The ADC therefore wins the first contest after reset.
  - Uncontested claims always win.
- ana_up: loads ana_up_cfg only while the ADC FSM is in A_IDLE; frozen otherwise.
- Stray inputs: adc_done/i2c_done outside A_CONV/I_OWN are ignored. A req dropping before grant is a protocol violation; the FSM still completes the handshake.
- busy = (ADC FSM != A_IDLE) | (I2C FSM != I_IDLE).
- rst asserted mid-operation: all outputs return to reset values immediately (async); FSMs return to idle.
- All outputs are registered; no combinational input-to-output paths.

Test Plan:
- Reset with SETTLE_CYCLES=16, then adc_req with chan=2 -> dig_io_iso=6'b000100 on the next edge; adc_gnt=1 after 17 edges; adc_done -> iso=0 and gnt=0 on the same edge.
- adc_req chan=4 while I2C is idle -> i2c_enable=0 and iso[4]=1 on the next edge; adc_gnt after 17 edges. Then i2c_req -> i2c_gnt only after adc_done plus 33 edges (RECOVER_CYCLES=32).
- adc_req chan=5 and i2c_req rise on the same edge, repeated 3 times -> grant order ADC, I2C, ADC. i2c_enable is never 1 while adc_gnt=1 with chan 4/5.
- i2c_gnt=1 (I_OWN), then adc_req chan=1 -> adc_gnt after 17 edges with i2c_gnt still 1. Separately, adc_req chan=4 -> waits in A_WAIT until i2c_done, then settles.
- adc_req chan=7 -> adc_gnt after 1 edge, iso=0. Toggle ana_up_cfg during A_CONV -> ana_up unchanged until adc_done.
- Assert rst during A_SETTLE (chan=4) -> i2c_enable=1, iso=0, adc_gnt=0, busy=0 without waiting for a clock edge.
